// File: rtl/wnd3x3_linebuf.sv
// rtl/wnd3x3_linebuf.sv - streaming 3x3 window generator with two line buffers (valid-only windows).
// Optional frame-done pulse output enabled by `define WND_FRAME_DONE_EN.
module wnd3x3_linebuf #(
    parameter int FEATURE_WIDTH = 8,
    parameter int WINDOW_SIZE   = 9,
    parameter int IMG_W         = 32,
    parameter int IMG_H         = 32,
    parameter int CNT_W         = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wnd_clr,
    input  logic [FEATURE_WIDTH-1:0]               in_pix,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [WINDOW_SIZE*FEATURE_WIDTH-1:0]   xwnd_3x3,
    output logic                                   out_valid,
    input  logic                                   out_ready
`ifdef WND_FRAME_DONE_EN
    ,
    output logic                                   wnd_done
`endif
);

    localparam int FW = FEATURE_WIDTH;
    localparam int XW = WINDOW_SIZE * FEATURE_WIDTH;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [FW-1:0]    lb0_mem [IMG_W];
    logic [FW-1:0]    lb1_mem [IMG_W];

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [XW-1:0]    win_q, win_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             gen_wnd;
    logic [AW-1:0]    col_idx;
    logic [FW-1:0]    lb_top;
    logic [FW-1:0]    lb_mid;

    assign col_idx   = col_q[AW-1:0];
    assign lb_top    = lb1_mem[col_idx];
    assign lb_mid    = lb0_mem[col_idx];
    assign in_ready  = !wnd_clr && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign col_last  = (col_q == CNT_W'(IMG_W - 1));
    assign row_last  = (row_q == CNT_W'(IMG_H - 1));
    assign gen_wnd   = accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));
    assign out_valid = valid_q;
    assign xwnd_3x3  = win_q;

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        win_d   = win_q;
        valid_d = valid_q;
        if (wnd_clr) begin
            row_d   = '0;
            col_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            // Shift columns left; new right column is {oldest row, middle row, incoming pixel}.
            win_d = {in_pix, win_q[8*FW +: FW], win_q[7*FW +: FW],
                     lb_mid, win_q[5*FW +: FW], win_q[4*FW +: FW],
                     lb_top, win_q[2*FW +: FW], win_q[1*FW +: FW]};
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
            if (gen_wnd) begin
                valid_d = 1'b1;
            end else if (out_ready) begin
                valid_d = 1'b0;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
            valid_q <= valid_d;
        end
    end

    // Line buffers carry no reset: rows 0/1 never emit windows, so stale contents stay hidden.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb1_mem[col_idx] <= lb_mid;
            lb0_mem[col_idx] <= in_pix;
        end
    end

`ifdef WND_FRAME_DONE_EN
    logic last_q, last_d;
    logic done_q, done_d;

    always_comb begin
        last_d = last_q;
        done_d = 1'b0;
        if (wnd_clr) begin
            last_d = 1'b0;
        end else begin
            done_d = valid_q && out_ready && last_q;
            if (gen_wnd) begin
                last_d = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            last_q <= last_d;
            done_q <= done_d;
        end
    end

    assign wnd_done = done_q;
`endif

endmodule

// File: tb/tb_wnd3x3_linebuf.sv
// tb/tb_wnd3x3_linebuf.sv - randomized scoreboard bench for wnd3x3_linebuf on a 4x4 image.
module tb_wnd3x3_linebuf;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XW = 72;

    logic          clk;
    logic          rst;
    logic          wnd_clr;
    logic [7:0]    in_pix;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] xwnd_3x3;
    logic          out_valid;
    logic          out_ready;
`ifdef WND_FRAME_DONE_EN
    logic          wnd_done;
`endif

    wnd3x3_linebuf #(
        .FEATURE_WIDTH(8),
        .WINDOW_SIZE  (9),
        .IMG_W        (W),
        .IMG_H        (H),
        .CNT_W        (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wnd_clr  (wnd_clr),
        .in_pix   (in_pix),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xwnd_3x3 (xwnd_3x3),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef WND_FRAME_DONE_EN
        ,
        .wnd_done (wnd_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] w;
        bit            last;
    } exp_t;

    exp_t          sb[$];
    logic [XW-1:0] got[$];
    logic [7:0]    img [H][W];
    int            n_pix;
    int            n_checks;
    int            n_pass;
    bit            last_acc;
    bit            done_exp;

    localparam logic [XW-1:0] WIN_FIRST  = 72'h0A0908060504020100;
    localparam logic [XW-1:0] WIN_LAST   = 72'h0F0E0D0B0A09070605;
    localparam logic [XW-1:0] WIN_FRAME2 = 72'h6E6D6C6A6968666564;

    task automatic chk(input string tag, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Reference: store every accepted pixel at its raster position, cut windows from the image.
    task automatic model_accept(input logic [7:0] px);
        int r, c;
        exp_t e;
        r = n_pix / W;
        c = n_pix % W;
        img[r][c] = px;
        if (r >= 2 && c >= 2) begin
            e.w = '0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    e.w[8*(3*dr+dc) +: 8] = img[r-2+dr][c-2+dc];
            e.last = (r == H-1) && (c == W-1);
            sb.push_back(e);
        end
        n_pix = (n_pix + 1) % (W*H);
    endtask

    task automatic tick(input logic iv, input logic [7:0] px, input logic ordy,
                        input logic clr, input logic rs);
        bit exp_ov, exp_rdy, acc, hs;
        in_valid  = iv;
        in_pix    = px;
        out_ready = ordy;
        wnd_clr   = clr;
        rst       = rs;
        #1;
        exp_ov  = (sb.size() != 0);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) chk("xwnd", xwnd_3x3, sb[0].w);
        exp_rdy = !clr && (!exp_ov || ordy);
        chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        hs  = exp_ov && ordy;
        @(posedge clk);
        if (rs || clr) begin
            sb.delete();
            n_pix    = 0;
            done_exp = 0;
            acc      = 0;
        end else begin
            done_exp = hs && sb[0].last;
            if (hs) begin
                got.push_back(sb[0].w);
                void'(sb.pop_front());
            end
            if (acc) model_accept(px);
        end
        last_acc = acc;
        @(negedge clk);
`ifdef WND_FRAME_DONE_EN
        chk("wnd_done", wnd_done, done_exp);
`endif
    endtask

    task automatic push(input logic [7:0] px, input int vpct, input int rpct);
        int  guard;
        bit  done;
        guard = 0;
        done  = 0;
        while (!done) begin
            tick(($urandom_range(99) < vpct), px, ($urandom_range(99) < rpct), 1'b0, 1'b0);
            if (last_acc) done = 1;
            guard++;
            if (guard > 500 && !done) begin
                chk("push_timeout", 0, 1);
                done = 1;
            end
        end
    endtask

    task automatic drain(input int k);
        repeat (k) tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic full_frame(input int base);
        for (int p = 0; p < W*H; p++) push(8'(base + p), 100, 100);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_pix     = 0;
        done_exp  = 0;
        rst       = 1'b1;
        wnd_clr   = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_xwnd", xwnd_3x3, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef WND_FRAME_DONE_EN
        chk("rst_wnd_done", wnd_done, 0);
`endif
        rst = 1'b0;

        got.delete();
        full_frame(0);
        drain(3);
        chk("s1_count", got.size(), 4);
        chk("s1_first", got[0], WIN_FIRST);
        chk("s1_last", got[3], WIN_LAST);

        got.delete();
        for (int p = 0; p <= 10; p++) push(8'(p), 100, 100);
        repeat (5) begin
            tick(1'b1, 8'd11, 1'b0, 1'b0, 1'b0);
            chk("s2_hold", xwnd_3x3, WIN_FIRST);
            chk("s2_in_ready", in_ready, 0);
        end
        for (int p = 11; p < 16; p++) push(8'(p), 100, 100);
        drain(3);
        chk("s2_count", got.size(), 4);
        chk("s2_first", got[0], WIN_FIRST);
        chk("s2_last", got[3], WIN_LAST);

        got.delete();
        full_frame(0);
        full_frame(100);
        drain(3);
        chk("s3_count", got.size(), 8);
        chk("s3_frame2", got[4], WIN_FRAME2);

        got.delete();
        for (int p = 0; p <= 6; p++) push(8'(p), 100, 100);
        tick(1'b1, 8'd7, 1'b1, 1'b1, 1'b0);
        full_frame(0);
        drain(3);
        chk("s4_count", got.size(), 4);
        chk("s4_first", got[0], WIN_FIRST);
        chk("s4_last", got[3], WIN_LAST);

        for (int p = 0; p <= 10; p++) push(8'(p), 100, 100);
        chk("s5_pre_valid", out_valid, 1);
        tick(1'b1, 8'd11, 1'b0, 1'b0, 1'b1);
        chk("s5_out_valid", out_valid, 0);
        chk("s5_xwnd", xwnd_3x3, 0);
        chk("s5_in_ready", in_ready, 1);
        got.delete();
        full_frame(0);
        drain(3);
        chk("s5_count", got.size(), 4);
        chk("s5_first", got[0], WIN_FIRST);
        chk("s5_last", got[3], WIN_LAST);

        got.delete();
        repeat (3) begin
            for (int p = 0; p < W*H; p++) push(8'($urandom_range(255)), 70, 60);
        end
        drain(4);
        chk("s6_count", got.size(), 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
